// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd: single-clock 5-stage MIPS32 pipeline (IF ID EX MEM WB) with Harvard memories,
// start/halt run control, program-load and debug ports, and retire/stall counters.
// Build option PIPE_FWD_EN: operand forwarding plus a 1-cycle load-use interlock. Without it,
// ID waits until every in-flight producer of its source registers has left WB.
module pipe_mips32_fwd #(
   parameter int unsigned IMEM_DEPTH = 1024,
   parameter int unsigned DMEM_DEPTH = 1024,
   parameter int unsigned RESET_PC   = 0,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          prog_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
   input  logic [31:0]                   prog_wdata,
   input  logic [4:0]                    dbg_raddr,
   output logic [31:0]                   dbg_rdata,
   input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_maddr,
   output logic [31:0]                   dbg_mdata,
   output logic                          running,
   output logic                          halted,
   output logic [CNT_W-1:0]              instr_count,
   output logic [CNT_W-1:0]              stall_count
);
   localparam int unsigned IAW = $clog2(IMEM_DEPTH);
   localparam int unsigned DAW = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OpAdd = 6'b000000, OpSub = 6'b000001, OpAnd = 6'b000010;
   localparam logic [5:0] OpOr = 6'b000011, OpSlt = 6'b000100, OpMul = 6'b000101;
   localparam logic [5:0] OpLw = 6'b001000, OpSw = 6'b001001, OpAddi = 6'b001010;
   localparam logic [5:0] OpSubi = 6'b001011, OpSlti = 6'b001100;
   localparam logic [5:0] OpBneqz = 6'b001101, OpBeqz = 6'b001110;

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] rf   [32];

   logic             running_q, halted_q, fetch_stop_q;
   logic [IAW-1:0]   pc_q;
   logic [CNT_W-1:0] instr_cnt_q, stall_cnt_q;
   // IF/ID
   logic             ifid_valid_q;
   logic [31:0]      ifid_ir_q;
   logic [IAW-1:0]   ifid_npc_q;
   // ID/EX
   logic             idex_valid_q, idex_wr_q, idex_hlt_q;
   logic [31:0]      idex_ir_q, idex_a_q, idex_b_q;
   logic [IAW-1:0]   idex_npc_q;
   logic [4:0]       idex_dst_q;
   // EX/MEM
   logic             exmem_valid_q, exmem_wr_q, exmem_ld_q, exmem_st_q, exmem_hlt_q;
   logic [31:0]      exmem_res_q, exmem_sd_q;
   logic [4:0]       exmem_dst_q;
   // MEM/WB
   logic             memwb_valid_q, memwb_wr_q, memwb_hlt_q;
   logic [31:0]      memwb_res_q;
   logic [4:0]       memwb_dst_q;

   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic        id_use_rs, id_use_rt, id_wr, id_hlt, id_stall;
   logic [31:0] id_a, id_b;
   logic [5:0]  ex_op;
   logic [4:0]  ex_rs, ex_rt;
   logic [31:0] ex_a, ex_b, ex_imm, ex_res;
   logic        ex_ld, ex_st, ex_taken;
   logic [IAW-1:0] ex_target;

   // ID: decode register usage and read the write-first register file
   always_comb begin
      id_op     = ifid_ir_q[31:26];
      id_rs     = ifid_ir_q[25:21];
      id_rt     = ifid_ir_q[20:16];
      id_dst    = ifid_ir_q[20:16];
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
      id_wr     = 1'b0;
      id_hlt    = 1'b0;
      case (id_op)
         OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: begin
            id_use_rs = 1'b1;
            id_use_rt = 1'b1;
            id_wr     = 1'b1;
            id_dst    = ifid_ir_q[15:11];
         end
         OpAddi, OpSubi, OpSlti, OpLw: begin
            id_use_rs = 1'b1;
            id_wr     = 1'b1;
         end
         OpSw: begin
            id_use_rs = 1'b1;
            id_use_rt = 1'b1;
         end
         OpBneqz, OpBeqz: id_use_rs = 1'b1;
         default: id_hlt = 1'b1;  // HLT and every unknown opcode
      endcase
      if (!ifid_valid_q) begin
         id_use_rs = 1'b0;
         id_use_rt = 1'b0;
         id_wr     = 1'b0;
         id_hlt    = 1'b0;
      end
      if (id_dst == 5'd0) id_wr = 1'b0;
      id_a = (id_rs == 5'd0) ? 32'd0 :
             (memwb_wr_q && memwb_dst_q == id_rs) ? memwb_res_q : rf[id_rs];
      id_b = (id_rt == 5'd0) ? 32'd0 :
             (memwb_wr_q && memwb_dst_q == id_rt) ? memwb_res_q : rf[id_rt];
   end

   // ID hazard detection
   always_comb begin
      id_stall = 1'b0;
`ifdef PIPE_FWD_EN
      // only a load in EX cannot be forwarded in time
      if (idex_wr_q && ex_ld && ((id_use_rs && idex_dst_q == id_rs) ||
                                 (id_use_rt && idex_dst_q == id_rt))) id_stall = 1'b1;
`else
      if (id_use_rs && ((idex_wr_q && idex_dst_q == id_rs) ||
                        (exmem_wr_q && exmem_dst_q == id_rs) ||
                        (memwb_wr_q && memwb_dst_q == id_rs))) id_stall = 1'b1;
      if (id_use_rt && ((idex_wr_q && idex_dst_q == id_rt) ||
                        (exmem_wr_q && exmem_dst_q == id_rt) ||
                        (memwb_wr_q && memwb_dst_q == id_rt))) id_stall = 1'b1;
`endif
   end

   // EX: operand forwarding, ALU, address generation and branch resolution
   always_comb begin
      ex_op  = idex_ir_q[31:26];
      ex_rs  = idex_ir_q[25:21];
      ex_rt  = idex_ir_q[20:16];
      ex_imm = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
      ex_a   = idex_a_q;
      ex_b   = idex_b_q;
`ifdef PIPE_FWD_EN
      // wr flags are never set for R0, so R0 is never overridden
      if (memwb_wr_q && memwb_dst_q == ex_rs) ex_a = memwb_res_q;
      if (memwb_wr_q && memwb_dst_q == ex_rt) ex_b = memwb_res_q;
      if (exmem_wr_q && !exmem_ld_q && exmem_dst_q == ex_rs) ex_a = exmem_res_q;
      if (exmem_wr_q && !exmem_ld_q && exmem_dst_q == ex_rt) ex_b = exmem_res_q;
`endif
      case (ex_op)
         OpAdd:        ex_res = ex_a + ex_b;
         OpSub:        ex_res = ex_a - ex_b;
         OpAnd:        ex_res = ex_a & ex_b;
         OpOr:         ex_res = ex_a | ex_b;
         OpSlt:        ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
         OpMul:        ex_res = ex_a * ex_b;
         OpAddi:       ex_res = ex_a + ex_imm;
         OpSubi:       ex_res = ex_a - ex_imm;
         OpSlti:       ex_res = {31'd0, $signed(ex_a) < $signed(ex_imm)};
         OpLw, OpSw:   ex_res = ex_a + ex_imm;
         default:      ex_res = 32'd0;
      endcase
      ex_ld     = idex_valid_q && (ex_op == OpLw);
      ex_st     = idex_valid_q && (ex_op == OpSw);
      ex_taken  = idex_valid_q && (((ex_op == OpBeqz) && (ex_a == 32'd0)) ||
                                   ((ex_op == OpBneqz) && (ex_a != 32'd0)));
      ex_target = idex_npc_q + ex_imm[IAW-1:0];
   end

   // Pipeline advance, run control and counters
   always_ff @(posedge clk) begin
      if (rst || (start && !running_q)) begin
         running_q     <= !rst;
         halted_q      <= 1'b0;
         fetch_stop_q  <= 1'b0;
         pc_q          <= IAW'(RESET_PC);
         instr_cnt_q   <= '0;
         stall_cnt_q   <= '0;
         ifid_valid_q  <= 1'b0;
         idex_valid_q  <= 1'b0;
         idex_wr_q     <= 1'b0;
         idex_hlt_q    <= 1'b0;
         exmem_valid_q <= 1'b0;
         exmem_wr_q    <= 1'b0;
         exmem_ld_q    <= 1'b0;
         exmem_st_q    <= 1'b0;
         exmem_hlt_q   <= 1'b0;
         memwb_valid_q <= 1'b0;
         memwb_wr_q    <= 1'b0;
         memwb_hlt_q   <= 1'b0;
      end else if (running_q) begin
         if (memwb_valid_q) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
         if (memwb_hlt_q) begin
            running_q <= 1'b0;
            halted_q  <= 1'b1;
         end
         memwb_valid_q <= exmem_valid_q;
         memwb_wr_q    <= exmem_wr_q;
         memwb_hlt_q   <= exmem_hlt_q;
         memwb_dst_q   <= exmem_dst_q;
         memwb_res_q   <= exmem_ld_q ? dmem[exmem_res_q[DAW-1:0]] : exmem_res_q;
         exmem_valid_q <= idex_valid_q;
         exmem_wr_q    <= idex_wr_q;
         exmem_ld_q    <= ex_ld;
         exmem_st_q    <= ex_st;
         exmem_hlt_q   <= idex_hlt_q;
         exmem_dst_q   <= idex_dst_q;
         exmem_res_q   <= ex_res;
         exmem_sd_q    <= ex_b;
         if (ex_taken) begin
            // taken branch wins over interlock and HLT fetch stop
            pc_q         <= ex_target;
            ifid_valid_q <= 1'b0;
            idex_valid_q <= 1'b0;
            idex_wr_q    <= 1'b0;
            idex_hlt_q   <= 1'b0;
            fetch_stop_q <= 1'b0;
         end else if (id_stall) begin
            idex_valid_q <= 1'b0;
            idex_wr_q    <= 1'b0;
            idex_hlt_q   <= 1'b0;
            stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
         end else begin
            idex_valid_q <= ifid_valid_q;
            idex_wr_q    <= id_wr;
            idex_hlt_q   <= id_hlt;
            idex_ir_q    <= ifid_ir_q;
            idex_a_q     <= id_a;
            idex_b_q     <= id_b;
            idex_npc_q   <= ifid_npc_q;
            idex_dst_q   <= id_dst;
            if (fetch_stop_q || id_hlt) begin
               fetch_stop_q <= 1'b1;
               ifid_valid_q <= 1'b0;
            end else begin
               ifid_valid_q <= 1'b1;
               ifid_ir_q    <= imem[pc_q];
               ifid_npc_q   <= pc_q + IAW'(1);
               pc_q         <= pc_q + IAW'(1);
            end
         end
      end
   end

   // Register file: cleared on reset, written from WB
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (running_q && memwb_wr_q) begin
         rf[memwb_dst_q] <= memwb_res_q;
      end
   end

   // Memories keep contents across reset: program load while idle, store commit in MEM
   always_ff @(posedge clk) begin
      if (!rst && prog_we && !running_q) imem[prog_addr] <= prog_wdata;
      if (!rst && running_q && exmem_st_q) dmem[exmem_res_q[DAW-1:0]] <= exmem_sd_q;
   end

   assign dbg_rdata   = rf[dbg_raddr];
   assign dbg_mdata   = dmem[dbg_maddr];
   assign running     = running_q;
   assign halted      = halted_q;
   assign instr_count = instr_cnt_q;
   assign stall_count = stall_cnt_q;

endmodule
